// File: rtl/values_ram_arbiter.sv
// Two-port (CPU / debug) arbiter and setup-strobe-wait sequencer for the
// single-port, strobe-clocked values RAM.
module values_ram_arbiter #(
   parameter bit CPU_PRIO = 1'b1,
   parameter int RD_LAT   = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic       cpu_gnt,
   output logic       cpu_done,
   output logic [7:0] cpu_rdata,
   input  logic       dbg_req,
   input  logic       dbg_we,
   input  logic [7:0] dbg_addr,
   input  logic [7:0] dbg_wdata,
   output logic       dbg_gnt,
   output logic       dbg_done,
   output logic [7:0] dbg_rdata,
   output logic [7:0] ram_addr,
   output logic [7:0] ram_wdata,
   output logic       ram_we,
   output logic       ram_strobe,
   input  logic [7:0] ram_rdata
);

   generate
      if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
         $error("values_ram_arbiter: RD_LAT must be in 1..4");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_DONE} state_t;

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       we_q, we_d;
   logic [2:0] cnt_q, cnt_d;
   logic       last_dbg_q, last_dbg_d;
   logic       cpu_gnt_q, cpu_gnt_d, dbg_gnt_q, dbg_gnt_d;
   logic       cpu_done_q, cpu_done_d, dbg_done_q, dbg_done_d;
   logic [7:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
   logic [7:0] ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d;
   logic       ram_we_q, ram_we_d, ram_strobe_q, ram_strobe_d;
   logic       pick_dbg;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      last_dbg_d   = last_dbg_q;
      cpu_gnt_d    = cpu_gnt_q;
      dbg_gnt_d    = dbg_gnt_q;
      cpu_done_d   = 1'b0;
      dbg_done_d   = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_we_d     = ram_we_q;
      ram_strobe_d = 1'b0;
      // On a tie, round-robin hands the RAM to whichever port did not win last
      pick_dbg     = dbg_req && (!cpu_req || (!CPU_PRIO && !last_dbg_q));

      case (state_q)
         S_IDLE: begin
            if (cpu_req || dbg_req) begin
               state_d     = S_SETUP;
               owner_d     = pick_dbg;
               cpu_gnt_d   = !pick_dbg;
               dbg_gnt_d   = pick_dbg;
               we_d        = pick_dbg ? dbg_we    : cpu_we;
               ram_we_d    = pick_dbg ? dbg_we    : cpu_we;
               ram_addr_d  = pick_dbg ? dbg_addr  : cpu_addr;
               ram_wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
            end
         end
         S_SETUP: begin
            state_d      = S_STROBE;
            ram_strobe_d = 1'b1;
         end
         S_STROBE: begin
            if (we_q) begin
               state_d    = S_DONE;
               ram_we_d   = 1'b0;
               cpu_done_d = !owner_q;
               dbg_done_d = owner_q;
            end else begin
               state_d = S_WAIT;
               cnt_d   = 3'(RD_LAT);
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d    = S_DONE;
               cpu_done_d = !owner_q;
               dbg_done_d = owner_q;
               if (owner_q) dbg_rdata_d = ram_rdata;
               else         cpu_rdata_d = ram_rdata;
            end
         end
         S_DONE: begin
            state_d    = S_IDLE;
            cpu_gnt_d  = 1'b0;
            dbg_gnt_d  = 1'b0;
            last_dbg_d = owner_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A low reset aborts any transaction at this edge; last winner starts as debug
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         cnt_q        <= 3'd0;
         last_dbg_q   <= 1'b1;
         cpu_gnt_q    <= 1'b0;
         dbg_gnt_q    <= 1'b0;
         cpu_done_q   <= 1'b0;
         dbg_done_q   <= 1'b0;
         cpu_rdata_q  <= 8'h00;
         dbg_rdata_q  <= 8'h00;
         ram_addr_q   <= 8'h00;
         ram_wdata_q  <= 8'h00;
         ram_we_q     <= 1'b0;
         ram_strobe_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         last_dbg_q   <= last_dbg_d;
         cpu_gnt_q    <= cpu_gnt_d;
         dbg_gnt_q    <= dbg_gnt_d;
         cpu_done_q   <= cpu_done_d;
         dbg_done_q   <= dbg_done_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_we_q     <= ram_we_d;
         ram_strobe_q <= ram_strobe_d;
      end
   end

   assign cpu_gnt    = cpu_gnt_q;
   assign dbg_gnt    = dbg_gnt_q;
   assign cpu_done   = cpu_done_q;
   assign dbg_done   = dbg_done_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign dbg_rdata  = dbg_rdata_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign ram_we     = ram_we_q;
   assign ram_strobe = ram_strobe_q;

endmodule

// File: tb/tb_values_ram_arbiter.sv
// Bench for values_ram_arbiter: a round-robin and a fixed-priority instance share
// the request inputs; each has its own strobe-clocked RAM model.
module tb_values_ram_arbiter;

   localparam int RD_LAT = 2;

   logic       clk, reset;
   logic       cpu_req, cpu_we, dbg_req, dbg_we;
   logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

   logic       a_cpu_gnt, a_cpu_done, a_dbg_gnt, a_dbg_done, a_ram_we, a_ram_strobe;
   logic [7:0] a_cpu_rdata, a_dbg_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
   logic       b_cpu_gnt, b_cpu_done, b_dbg_gnt, b_dbg_done, b_ram_we, b_ram_strobe;
   logic [7:0] b_cpu_rdata, b_dbg_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;

   bit [7:0]   mem_a [256];
   bit [7:0]   mem_b [256];
   bit [7:0]   ref_mem [256];
   logic [7:0] exp_cpu_rd, exp_dbg_rd;

   int         checks = 0;
   int         failures = 0;
   bit         mon_en = 1'b0;
   bit         a_cp, a_dp, b_cp, b_dp;
   bit         q_a[$];
   bit         q_b[$];

   values_ram_arbiter #(.CPU_PRIO(1'b0), .RD_LAT(RD_LAT)) u_rr (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(a_cpu_gnt), .cpu_done(a_cpu_done), .cpu_rdata(a_cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(a_dbg_gnt), .dbg_done(a_dbg_done), .dbg_rdata(a_dbg_rdata),
      .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_we(a_ram_we),
      .ram_strobe(a_ram_strobe), .ram_rdata(a_ram_rdata)
   );

   values_ram_arbiter #(.CPU_PRIO(1'b1), .RD_LAT(RD_LAT)) u_fp (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(b_cpu_gnt), .cpu_done(b_cpu_done), .cpu_rdata(b_cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(b_dbg_gnt), .dbg_done(b_dbg_done), .dbg_rdata(b_dbg_rdata),
      .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we),
      .ram_strobe(b_ram_strobe), .ram_rdata(b_ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models: the strobe edge writes, or loads the read register for later cycles
   always @(posedge clk) begin
      if (a_ram_strobe) begin
         if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
         else          a_ram_rdata <= mem_a[a_ram_addr];
      end
      if (b_ram_strobe) begin
         if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
         else          b_ram_rdata <= mem_b[b_ram_addr];
      end
   end

   // Grant-order monitor: one queue entry per rising gnt (0 = CPU, 1 = debug)
   always @(negedge clk) begin
      a_cp <= a_cpu_gnt;
      a_dp <= a_dbg_gnt;
      b_cp <= b_cpu_gnt;
      b_dp <= b_dbg_gnt;
      if (mon_en) begin
         if (a_cpu_gnt && !a_cp) q_a.push_back(1'b0);
         if (a_dbg_gnt && !a_dp) q_a.push_back(1'b1);
         if (b_cpu_gnt && !b_cp) q_b.push_back(1'b0);
         if (b_dbg_gnt && !b_dp) q_b.push_back(1'b1);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, ".a_flags"}, 32'({a_cpu_gnt, a_cpu_done, a_dbg_gnt, a_dbg_done,
                                          a_ram_we, a_ram_strobe}), 32'd0);
      checkOutput({tag, ".a_addr"},  32'(a_ram_addr),  32'd0);
      checkOutput({tag, ".a_wdata"}, 32'(a_ram_wdata), 32'd0);
      checkOutput({tag, ".a_cpu_rd"}, 32'(a_cpu_rdata), 32'd0);
      checkOutput({tag, ".a_dbg_rd"}, 32'(a_dbg_rdata), 32'd0);
      checkOutput({tag, ".b_flags"}, 32'({b_cpu_gnt, b_cpu_done, b_dbg_gnt, b_dbg_done,
                                          b_ram_we, b_ram_strobe}), 32'd0);
      checkOutput({tag, ".b_bus"},   32'({b_ram_addr, b_ram_wdata, b_cpu_rdata, b_dbg_rdata}), 32'd0);
   endtask

   // One single-port transaction on the round-robin instance, with timing and data checks
   task automatic applyStimulus(input bit port, input bit we, input logic [7:0] addr,
                                input logic [7:0] wdata, input bit disturb);
      int         n, gnt_own, gnt_oth, done_oth, strobes, strobe_cyc, done_cyc, exp_done;
      logic       s_we, own_gnt, oth_gnt, own_done, oth_done;
      logic [7:0] s_addr, s_wdata, exp_rd;
      exp_done = we ? 3 : 3 + RD_LAT;
      exp_rd   = ref_mem[addr];
      n = 0; gnt_own = 0; gnt_oth = 0; done_oth = 0; strobes = 0;
      strobe_cyc = -1; done_cyc = -1;
      s_we = 1'b0; s_addr = 8'h00; s_wdata = 8'h00;
      @(negedge clk);
      if (port) begin
         dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end
      while (done_cyc < 0 && n < 20) begin
         @(negedge clk);
         n++;
         own_gnt  = port ? a_dbg_gnt  : a_cpu_gnt;
         oth_gnt  = port ? a_cpu_gnt  : a_dbg_gnt;
         own_done = port ? a_dbg_done : a_cpu_done;
         oth_done = port ? a_cpu_done : a_dbg_done;
         if (own_gnt) gnt_own++;
         if (oth_gnt) gnt_oth++;
         if (oth_done) done_oth++;
         if (a_ram_strobe) begin
            strobes++;
            strobe_cyc = n;
            s_addr = a_ram_addr; s_we = a_ram_we; s_wdata = a_ram_wdata;
         end
         if (own_done) done_cyc = n;
         if (disturb && n == 2) begin
            if (port) begin dbg_req = 1'b0; dbg_addr = ~addr; dbg_wdata = ~wdata; end
            else      begin cpu_req = 1'b0; cpu_addr = ~addr; cpu_wdata = ~wdata; end
         end
      end
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      checkOutput("done_cycle", done_cyc, exp_done);
      checkOutput("own_gnt_cycles", gnt_own, exp_done);
      checkOutput("other_gnt_cycles", gnt_oth, 0);
      checkOutput("other_done", done_oth, 0);
      checkOutput("strobe_count", strobes, 1);
      checkOutput("strobe_cycle", strobe_cyc, 2);
      checkOutput("strobe_addr", 32'(s_addr), 32'(addr));
      checkOutput("strobe_we", 32'(s_we), 32'(we));
      if (we) begin
         checkOutput("strobe_wdata", 32'(s_wdata), 32'(wdata));
         ref_mem[addr] = wdata;
      end else if (port) begin
         exp_dbg_rd = exp_rd;
      end else begin
         exp_cpu_rd = exp_rd;
      end
      @(negedge clk);
      checkOutput("idle_gnt", 32'({a_cpu_gnt, a_dbg_gnt, a_ram_we, a_ram_strobe}), 32'd0);
      checkOutput("cpu_rdata", 32'(a_cpu_rdata), 32'(exp_cpu_rd));
      checkOutput("dbg_rdata", 32'(a_dbg_rdata), 32'(exp_dbg_rd));
   endtask

   initial begin
      bit         p, w;
      logic [7:0] ad, wd;
      int         strobes, dones;
      reset = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
      exp_cpu_rd = 8'h00;
      exp_dbg_rd = 8'h00;

      repeat (3) @(negedge clk);
      checkReset("reset_initial");
      reset = 1'b1;

      $display("[TB] directed write / read");
      applyStimulus(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);

      $display("[TB] random single-port transactions");
      for (int i = 0; i < 16; i++) begin
         p  = 1'($urandom);
         w  = 1'($urandom);
         ad = 8'($urandom_range(0, 15));
         wd = 8'($urandom);
         applyStimulus(p, w, ad, wd, 1'b0);
      end

      $display("[TB] request dropped and fields changed during STROBE");
      applyStimulus(1'b0, 1'b1, 8'h22, 8'h3C, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h22, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h22, 8'h00, 1'b1);

      $display("[TB] reset during WAIT");
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h22;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      cpu_req = 1'b0;
      @(negedge clk);
      checkReset("reset_in_wait");
      reset = 1'b1;
      exp_cpu_rd = 8'h00;
      exp_dbg_rd = 8'h00;
      strobes = 0;
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (a_ram_strobe) strobes++;
         if (a_cpu_done || a_dbg_done) dones++;
      end
      checkOutput("post_reset_strobes", strobes, 0);
      checkOutput("post_reset_dones", dones, 0);
      applyStimulus(1'b0, 1'b0, 8'h22, 8'h00, 1'b0);

      $display("[TB] both ports requesting continuously");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'($urandom); dbg_wdata = 8'($urandom);
      mon_en = 1'b1;
      repeat (34) @(negedge clk);
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      repeat (8) @(negedge clk);
      mon_en = 1'b0;
      checkOutput("rr_grant_count_ge8", 32'(q_a.size() >= 8), 32'd1);
      checkOutput("fp_grant_count_ge8", 32'(q_b.size() >= 8), 32'd1);
      for (int i = 0; i < 8 && i < q_a.size(); i++)
         checkOutput($sformatf("rr_grant[%0d]", i), 32'(q_a[i]), 32'(i % 2));
      for (int i = 0; i < 8 && i < q_b.size(); i++)
         checkOutput($sformatf("fp_grant[%0d]", i), 32'(q_b[i]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
